// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch path.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LO_REQ = 3'd1,
        LO_WR  = 3'd2,
        HI_REQ = 3'd3,
        HI_WR  = 3'd4
    } fetch_state_t;

    localparam logic IR_LOW  = 1'b0;
    localparam logic IR_HIGH = 1'b1;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/ack_timeout_counter.sv
// Counts cycles spent waiting for a memory ack; expired flags the last allowed cycle.
// Clear has priority over enable; expired is combinational from the count.
module ack_timeout_counter #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign expired = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/instruction_fetch_controller.sv
// Fetches one 16-bit instruction as two byte reads (PC, PC+1) and writes them into the IR.
// Control outputs are Moore-decoded from the state; PCLoad aborts any fetch in progress.
module instruction_fetch_controller
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] PC_RESET = '0,
    parameter int                TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCLoadValue,
    input  logic [7:0]        MemData,
    input  logic              MemAck,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        IRByte,
    output logic              IRWrite,
    output logic              IRLH,
    output logic              FetchDone,
    output logic              Busy,
    output logic              Error,
    output logic [ADDR_W-1:0] PC
);

    fetch_state_t state, state_nxt;

    logic in_req;
    logic ack_hit;
    logic timeout;
    logic start_ok;
    logic expired;

    assign in_req   = (state == LO_REQ) || (state == HI_REQ);
    // PCLoad outranks a coincident ack or timeout: the byte is dropped and PC is not bumped.
    assign ack_hit  = in_req && MemAck && !PCLoad;
    assign timeout  = in_req && !MemAck && !PCLoad && expired;
    assign start_ok = (state == IDLE) && Start && !PCLoad;

    ack_timeout_counter #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk    (Clock),
        .rst_n  (Reset),
        .clear  (!in_req || MemAck || PCLoad),
        .enable (in_req),
        .expired(expired)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start_ok) state_nxt = LO_REQ;
            LO_REQ:  if (ack_hit) state_nxt = LO_WR; else if (timeout) state_nxt = IDLE;
            LO_WR:   state_nxt = HI_REQ;
            HI_REQ:  if (ack_hit) state_nxt = HI_WR; else if (timeout) state_nxt = IDLE;
            HI_WR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (PCLoad) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        IRLH      = IR_LOW;
        FetchDone = 1'b0;
        Busy      = (state != IDLE);
        unique case (state)
            LO_REQ, HI_REQ: MemReq = 1'b1;
            LO_WR:          IRWrite = 1'b1;
            HI_WR: begin
                IRWrite   = 1'b1;
                IRLH      = IR_HIGH;
                FetchDone = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            PC     <= PC_RESET;
            IRByte <= '0;
            Error  <= 1'b0;
        end else begin
            if (PCLoad) begin
                PC <= PCLoadValue;
            end else if (ack_hit) begin
                PC <= PC + ADDR_W'(1);
            end
            if (ack_hit) begin
                IRByte <= MemData;
            end
            if (start_ok) begin
                Error <= 1'b0;
            end else if (timeout) begin
                Error <= 1'b1;
            end
        end
    end

    assign MemAddr = PC;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed and random checks of instruction_fetch_controller against a transaction-level model.
module tb_instruction_fetch_controller;

    localparam int TMO = 15;

    logic        Clock, Reset, Start, PCLoad, MemAck;
    logic [15:0] PCLoadValue;
    logic [7:0]  MemData;
    logic        MemReq, IRWrite, IRLH, FetchDone, Busy, Error;
    logic [15:0] MemAddr, PC;
    logic [7:0]  IRByte;

    instruction_fetch_controller #(
        .ADDR_W(16), .PC_RESET(16'h0000), .TIMEOUT(TMO)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .PCLoad(PCLoad),
        .PCLoadValue(PCLoadValue), .MemData(MemData), .MemAck(MemAck),
        .MemReq(MemReq), .MemAddr(MemAddr), .IRByte(IRByte), .IRWrite(IRWrite),
        .IRLH(IRLH), .FetchDone(FetchDone), .Busy(Busy), .Error(Error), .PC(PC)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_total = 0;
    int n_bad   = 0;
    int obs_req = 0, obs_wr = 0, obs_done = 0;

    // Model: an instruction in flight is "which byte" plus "waiting for data vs. writing it".
    bit        m_active, m_hi, m_wr, m_err;
    int        m_wait;
    bit [15:0] m_pc;
    bit [7:0]  m_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 0; m_hi = 0; m_wr = 0; m_err = 0; m_wait = 0;
        m_pc = 16'h0000; m_byte = 8'h00;
    endfunction

    function automatic void model_step();
        if (!Reset) begin
            model_reset();
        end else if (!m_active) begin
            if (PCLoad) m_pc = PCLoadValue;
            else if (Start) begin
                m_active = 1; m_hi = 0; m_wr = 0; m_wait = 0; m_err = 0;
            end
        end else if (PCLoad) begin
            m_pc = PCLoadValue;
            m_active = 0;
        end else if (m_wr) begin
            if (m_hi) m_active = 0;
            else begin
                m_hi = 1; m_wr = 0; m_wait = 0;
            end
        end else if (MemAck) begin
            m_byte = MemData;
            m_pc   = m_pc + 16'd1;
            m_wr   = 1;
        end else begin
            m_wait++;
            if (m_wait == TMO) begin
                m_active = 0;
                m_err    = 1;
            end
        end
    endfunction

    task automatic compare();
        bit wr;
        wr = m_active && m_wr;
        check("busy",    Busy,      m_active);
        check("memreq",  MemReq,    m_active && !m_wr);
        check("irwrite", IRWrite,   wr);
        check("irlh",    IRLH,      wr && m_hi);
        check("done",    FetchDone, wr && m_hi);
        check("pc",      PC,        m_pc);
        check("memaddr", MemAddr,   m_pc);
        check("irbyte",  IRByte,    m_byte);
        check("error",   Error,     m_err);
        if (MemReq === 1'b1)    obs_req++;
        if (IRWrite === 1'b1)   obs_wr++;
        if (FetchDone === 1'b1) obs_done++;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
        compare();
    endtask

    task automatic ack_byte(input int waits, input logic [7:0] d);
        MemAck = 1'b0;
        repeat (waits) tick();
        MemAck  = 1'b1;
        MemData = d;
        tick();
        MemAck = 1'b0;
    endtask

    int req0, wr0, done0, pct;
    logic [15:0] pc0;

    initial begin
        Reset = 1'b0; Start = 1'b0; PCLoad = 1'b0; MemAck = 1'b0;
        PCLoadValue = '0; MemData = '0;
        model_reset();
        #2 compare();
        @(negedge Clock) Reset = 1'b1;

        // Instant-ack fetch of 0x1234 from address 0
        Start = 1'b1; MemAck = 1'b1; MemData = 8'h34;
        tick();
        Start = 1'b0;
        check("t1_lo_addr", MemAddr, 16'h0000);
        tick();
        check("t1_lo_wr", {IRWrite, IRLH, IRByte}, {1'b1, 1'b0, 8'h34});
        MemData = 8'h12;
        tick();
        check("t1_hi_addr", MemAddr, 16'h0001);
        tick();
        check("t1_hi_wr", {IRWrite, IRLH, FetchDone, IRByte}, {1'b1, 1'b1, 1'b1, 8'h12});
        MemAck = 1'b0;
        tick();
        check("t1_pc", PC, 16'h0002);

        // Fetch across the top of the address space, 3 wait cycles per byte
        PCLoad = 1'b1; PCLoadValue = 16'hFFFF;
        tick();
        PCLoad = 1'b0;
        done0 = obs_done;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        ack_byte(3, 8'hA5);
        tick();
        check("t2_hi_addr", MemAddr, 16'h0000);
        ack_byte(3, 8'h5A);
        tick();
        check("t2_pc", PC, 16'h0001);
        check("t2_done_cnt", obs_done - done0, 1);
        check("t2_error", Error, 1'b0);

        // Timeout: no ack at all
        req0 = obs_req; wr0 = obs_wr; pc0 = PC;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (20) tick();
        check("t3_req_cycles", obs_req - req0, TMO);
        check("t3_error", Error, 1'b1);
        check("t3_pc", PC, pc0);
        check("t3_no_wr", obs_wr - wr0, 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        check("t3_err_clr", Error, 1'b0);
        ack_byte(0, 8'h11);
        tick();
        ack_byte(0, 8'h22);
        tick();

        // PCLoad coinciding with the high-byte ack aborts the fetch
        wr0 = obs_wr; done0 = obs_done;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        ack_byte(0, 8'h77);
        tick();
        PCLoad = 1'b1; PCLoadValue = 16'h0100; MemAck = 1'b1; MemData = 8'h88;
        tick();
        PCLoad = 1'b0; MemAck = 1'b0;
        tick();
        check("t4_pc", PC, 16'h0100);
        check("t4_busy", Busy, 1'b0);
        check("t4_wr_cnt", obs_wr - wr0, 1);
        check("t4_done_cnt", obs_done - done0, 0);

        // Asynchronous reset in HI_REQ
        Start = 1'b1;
        tick();
        Start = 1'b0;
        ack_byte(0, 8'h99);
        tick();
        check("t5_in_hireq", MemReq, 1'b1);
        #2 Reset = 1'b0;
        #1 model_reset();
        compare();
        check("t5_async_pc", PC, 16'h0000);
        @(negedge Clock) Reset = 1'b1;
        PCLoad = 1'b1; PCLoadValue = 16'h1234; Start = 1'b1;
        tick();
        PCLoad = 1'b0; Start = 1'b0;
        check("t5_load_only", {Busy, PC}, {1'b0, 16'h1234});
        tick();

        // Back-to-back fetches with Start held and instant acks
        done0 = obs_done; pc0 = PC;
        Start = 1'b1; MemAck = 1'b1;
        repeat (20) tick();
        Start = 1'b0; MemAck = 1'b0;
        tick();
        check("t6_done_cnt", obs_done - done0, 4);
        check("t6_pc", PC, pc0 + 16'd8);

        // Random traffic; ack likelihood varies by segment to reach timeouts too
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 4)
                0: pct = 90;
                1: pct = 50;
                2: pct = 10;
                default: pct = 3;
            endcase
            Start       = 1'($urandom_range(0, 1));
            PCLoad      = ($urandom_range(0, 99) < 3);
            PCLoadValue = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            MemData     = 8'($urandom);
            MemAck      = ($urandom_range(0, 99) < pct);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_controller.md
Name: instruction_fetch_controller

Overview:
- Upstream feeder of the 16-bit instruction register, which loads one byte per write: low byte with LH=0, high byte with LH=1.
- Owns the program counter and drives a byte-wide memory read handshake.
- Sequences two byte fetches per instruction, low byte at PC and high byte at PC+1, into the IR's Write/LH/I inputs.
- Signals completion to the control unit. Supports PC load for jumps/branches, an ack timeout and abort.

Parameters:
ADDR_W, 16, program counter / memory address width
PC_RESET, 0, PC value after reset
TIMEOUT, 15, max cycles waiting for MemAck per byte before error (range 1..255)

Ports:
Clock  input  1  system clock, all state updates on posedge
Reset  input  1  asynchronous, active-low reset
Start  input  1  request one instruction fetch; sampled only in IDLE
PCLoad  input  1  load PC from PCLoadValue; accepted in any state
PCLoadValue  input  ADDR_W  new PC value
MemData  input  8  read data from memory, valid when MemAck=1
MemAck  input  1  memory read-data-valid strobe
MemReq  output  1  memory read request
MemAddr  output  ADDR_W  memory address, always equal to PC
IRByte  output  8  byte for IR data input I (registered)
IRWrite  output  1  IR write enable
IRLH  output  1  IR half select: 0=low byte, 1=high byte
FetchDone  output  1  one-cycle pulse when the high byte is written to IR
Busy  output  1  high in every state except IDLE
Error  output  1  sticky timeout flag
PC  output  ADDR_W  current program counter

Behaviour:
- Reset (Reset=0, async): state=IDLE, PC=PC_RESET, IRByte=0, timeout count=0, Error=0. All outputs 0 except MemAddr=PC=PC_RESET.
- States: IDLE, LO_REQ, LO_WR, HI_REQ, HI_WR. Control outputs are Moore-decoded from the state register only.
  - MemReq=1 in LO_REQ and HI_REQ.
  - IRWrite=1 in LO_WR (IRLH=0) and HI_WR (IRLH=1).
  - FetchDone=1 in HI_WR only.
- IDLE:
  - PCLoad=1: PC<=PCLoadValue, stay IDLE; PCLoad has priority over Start.
  - Else Start=1: go to LO_REQ, clear Error and the timeout count.
- LO_REQ / HI_REQ:
  - MemAck=1 at an edge: IRByte<=MemData, PC<=PC+1 (mod 2^ADDR_W, so FFFF wraps to 0000), count<=0. Next state is LO_WR / HI_WR.
  - MemAck=0: count<=count+1. When count reaches TIMEOUT-1 with no ack: go to IDLE, Error<=1, PC unchanged, no IR write.
- LO_WR: one cycle, then HI_REQ.
- HI_WR: one cycle, then IDLE.
- Latency: with MemAck high in the first request cycle, FetchDone is asserted in the 4th cycle after the edge that samples Start. The IR high byte is captured at the edge ending HI_WR. Start to next-Start acceptance takes a minimum of 5 cycles.
- PCLoad while Busy:
  - Aborts the fetch: PC<=PCLoadValue, state<=IDLE, count<=0. No further IRWrite or FetchDone for that instruction.
  - PCLoad wins over a coincident MemAck: the data is discarded and there is no PC increment.
- MemAck outside LO_REQ/HI_REQ is ignored.
- Start outside IDLE is ignored; it is not queued.
- Error stays high until the next accepted Start or reset. PCLoad does not clear it.
- Reset asserted mid-fetch returns to the reset state immediately; any partially written IR contents are left to the IR.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum typedef (IDLE, LO_REQ, LO_WR, HI_REQ, HI_WR)
  - IR half-select constants IR_LOW=1'b0, IR_HIGH=1'b1
  - default TIMEOUT constant
- One sub-module is natural: `ack_timeout_counter`, 8-bit, with clear, enable and expired output, reused by any future memory-side requester.
- The PC register and FSM stay in the top module.

Test Plan:
- Reset, then Start with MemAck high every request cycle, MemData=8'h34 then 8'h12, PC_RESET=0 -> IRWrite/IRLH=0 with IRByte=34, then IRWrite/IRLH=1 with IRByte=12. FetchDone in the 4th cycle after Start; PC=0002; MemAddr sequence 0000, 0001.
- PCLoad with PCLoadValue=FFFF, then Start, ack after 3 wait cycles each byte -> MemAddr FFFF then 0000, PC=0001, FetchDone once, Error=0.
- Start with MemAck held low, TIMEOUT=15 -> MemReq high exactly 15 cycles, then IDLE, Error=1, PC unchanged, no IRWrite. A following successful Start clears Error.
- Start, ack low byte, then PCLoad=1 with value 0x0100 coinciding with the high-byte ack -> IDLE, PC=0100, only one IRWrite (low), no FetchDone.
- Reset pulsed low mid-HI_REQ (asynchronously, between edges) -> outputs drop immediately, PC=PC_RESET, Busy=0. Start in the same cycle as PCLoad in IDLE -> load only, no fetch.
- Back-to-back: Start held high continuously with instant acks -> new fetch accepted every 5 cycles, PC advances by 2 per FetchDone.
